// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, driver FSM states, opcode legality.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } drv_state_e;

    // Opcodes above XOR have no ALU operation behind them.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'(OP_XOR));
    endfunction

endpackage

// File: rtl/alu_sat_counter.sv
// Saturating up-counter, cleared by reset, holds at all-ones.
module alu_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    // Count up on inc until all-ones, then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Command-side driver for the registered 32-bit ALU: accepts a command,
// drives ALU operands, waits one ALU cycle, returns a tagged response.
// Optional build macro ALU_DRV_OPCHK_EN: illegal opcodes are not forwarded
// to the ALU and are answered with result 0 / error 1 by the driver itself.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [31:0]      alu_result,
    input  logic             alu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_error,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_EXEC = 2'(ST_EXEC);
    localparam logic [1:0] S_CAPT = 2'(ST_CAPT);
    localparam logic [1:0] S_RESP = 2'(ST_RESP);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             accept_c;
    logic             capture_c;
    logic             rsp_done_c;
    logic [TAG_W-1:0] tag_q;
`ifdef ALU_DRV_OPCHK_EN
    logic             op_bad_q;
`endif

    // Next-state and handshake event decode.
    always_comb begin
        state_nxt  = state;
        accept_c   = 1'b0;
        capture_c  = 1'b0;
        rsp_done_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept_c  = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = S_CAPT;
            end
            S_CAPT: begin
                capture_c = 1'b1;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_done_c = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; cmd_ready/busy registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == S_IDLE);
            busy      <= (state_nxt != S_IDLE);
        end
    end

    // Operand launch on accept, response capture, response retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= 3'(OP_ADD);
            tag_q      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
            rsp_tag    <= '0;
`ifdef ALU_DRV_OPCHK_EN
            op_bad_q   <= 1'b0;
`endif
        end else begin
            if (accept_c) begin
                tag_q <= cmd_tag;
`ifdef ALU_DRV_OPCHK_EN
                if (is_legal_op(cmd_op)) begin
                    alu_a      <= cmd_a;
                    alu_b      <= cmd_b;
                    alu_opcode <= cmd_op;
                    op_bad_q   <= 1'b0;
                end else begin
                    alu_a      <= '0;
                    alu_b      <= '0;
                    alu_opcode <= 3'(OP_AND);
                    op_bad_q   <= 1'b1;
                end
`else
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                alu_opcode <= cmd_op;
`endif
            end
            if (capture_c) begin
`ifdef ALU_DRV_OPCHK_EN
                rsp_result <= op_bad_q ? '0 : alu_result;
                rsp_error  <= op_bad_q | alu_error;
`else
                rsp_result <= alu_result;
                rsp_error  <= alu_error;
`endif
                rsp_tag    <= tag_q;
                rsp_valid  <= 1'b1;
            end
            if (rsp_done_c) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Error responses are counted when the consumer takes them.
    alu_sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rsp_done_c && rsp_error),
        .count (err_count)
    );

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: two instances (8-bit and 2-bit error counter)
// share stimulus; each drives its own behavioural registered ALU.
module tb_alu_cmd_driver;

    localparam int unsigned TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_tag;
    logic        rsp_ready;

    logic        cmd_ready1, rsp_valid1, rsp_error1, busy1, alu_error1;
    logic [31:0] alu_a1, alu_b1, rsp_result1, alu_result1;
    logic [2:0]  alu_op1;
    logic [3:0]  rsp_tag1;
    logic [7:0]  err_count1;

    logic        cmd_ready2, rsp_valid2, rsp_error2, busy2, alu_error2;
    logic [31:0] alu_a2, alu_b2, rsp_result2, alu_result2;
    logic [2:0]  alu_op2;
    logic [3:0]  rsp_tag2;
    logic [1:0]  err_count2;

    int checks   = 0;
    int failures = 0;

    // Reference model state (transaction level).
    bit          m_out;
    int          m_age;
    logic [31:0] m_a, m_b, m_res;
    logic [2:0]  m_op;
    logic        m_err;
    logic [3:0]  m_tag;
    int          m_cnt, m_cnt2;

    always #5 clk = ~clk;

    alu_cmd_driver #(.TAG_W(TAG_W), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_op1),
        .alu_result(alu_result1), .alu_error(alu_error1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_result(rsp_result1),
        .rsp_error(rsp_error1), .rsp_tag(rsp_tag1), .err_count(err_count1), .busy(busy1)
    );

    alu_cmd_driver #(.TAG_W(TAG_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_opcode(alu_op2),
        .alu_result(alu_result2), .alu_error(alu_error2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
        .rsp_error(rsp_error2), .rsp_tag(rsp_tag2), .err_count(err_count2), .busy(busy2)
    );

    // ALU behaviour: {error, result}; error on signed overflow or illegal opcode.
    function automatic logic [32:0] alu_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
        logic [31:0] r;
        logic        e;
        r = '0;
        e = 1'b0;
        case (op)
            3'd0: begin r = a + b; e = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin r = a - b; e = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: begin r = '0; e = 1'b1; end
        endcase
        return {e, r};
    endfunction

    // Registered ALUs (one cycle latency, share rst).
    always @(posedge clk or posedge rst) begin
        if (rst) {alu_error1, alu_result1} <= '0;
        else     {alu_error1, alu_result1} <= alu_calc(alu_a1, alu_b1, alu_op1);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) {alu_error2, alu_result2} <= '0;
        else     {alu_error2, alu_result2} <= alu_calc(alu_a2, alu_b2, alu_op2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge given the inputs driven for it.
    task automatic model_update(input logic v, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, input logic [3:0] tag,
                                input logic rr, input logic r);
        bit idle;
        bit rv;
        if (r) begin
            m_out = 0; m_age = 0; m_a = '0; m_b = '0; m_op = '0;
            m_cnt = 0; m_cnt2 = 0;
        end else begin
            idle = !m_out;
            rv   = m_out && (m_age >= 2);
            if (rv && rr) begin
                m_out = 0;
                if (m_err) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3)  m_cnt2++;
                end
            end else if (m_out && (m_age < 2)) begin
                m_age++;
            end
            if (v && idle) begin
                m_out = 1;
                m_age = 0;
                m_tag = tag;
`ifdef ALU_DRV_OPCHK_EN
                if (op > 3'd4) begin
                    m_a = '0; m_b = '0; m_op = 3'b010; m_res = '0; m_err = 1'b1;
                end else begin
                    m_a = a; m_b = b; m_op = op; {m_err, m_res} = alu_calc(a, b, op);
                end
`else
                m_a = a; m_b = b; m_op = op; {m_err, m_res} = alu_calc(a, b, op);
`endif
            end
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    task automatic compare_all();
        bit rv;
        rv = m_out && (m_age >= 2);
        chk("cmd_ready",  32'(cmd_ready1), 32'(!m_out));
        chk("busy",       32'(busy1),      32'(m_out));
        chk("rsp_valid",  32'(rsp_valid1), 32'(rv));
        chk("alu_a",      alu_a1,          m_a);
        chk("alu_b",      alu_b1,          m_b);
        chk("alu_opcode", 32'(alu_op1),    32'(m_op));
        chk("err_count",  32'(err_count1), 32'(m_cnt));
        chk("cmd_ready2", 32'(cmd_ready2), 32'(!m_out));
        chk("busy2",      32'(busy2),      32'(m_out));
        chk("rsp_valid2", 32'(rsp_valid2), 32'(rv));
        chk("alu_op2",    32'(alu_op2),    32'(m_op));
        chk("alu_a2",     alu_a2,          m_a);
        chk("alu_b2",     alu_b2,          m_b);
        chk("err_count2", 32'(err_count2), 32'(m_cnt2));
        if (rv) begin
            chk("rsp_result",  rsp_result1,      m_res);
            chk("rsp_error",   32'(rsp_error1),  32'(m_err));
            chk("rsp_tag",     32'(rsp_tag1),    32'(m_tag));
            chk("rsp_result2", rsp_result2,      m_res);
            chk("rsp_error2",  32'(rsp_error2),  32'(m_err));
            chk("rsp_tag2",    32'(rsp_tag2),    32'(m_tag));
        end
    endtask

    // One cycle: drive at the falling edge, cross the rising edge, compare.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [3:0] tag,
                        input logic rr, input logic r);
        cmd_valid = v; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        rsp_ready = rr; rst = r;
        model_update(v, a, b, op, tag, rr, r);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_step(input logic rr, input logic r);
        step(1'b0, 32'd0, 32'd0, 3'd0, 4'd0, rr, r);
    endtask

    // Full command with hand-computed literal expectations.
    task automatic run_cmd(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [3:0] tag, input int stall,
                           input logic [2:0] exp_op, input logic [31:0] exp_res,
                           input logic exp_err, input int exp_cnt, input int exp_cnt2);
        step(1'b1, a, b, op, tag, 1'b1, 1'b0);
        chk({nm, "_alu_opcode"}, 32'(alu_op1), 32'(exp_op));
        idle_step(1'b1, 1'b0);
        chk({nm, "_early_valid"}, 32'(rsp_valid1), 32'd0);
        idle_step(1'b0, 1'b0);
        chk({nm, "_valid"}, 32'(rsp_valid1), 32'd1);
        chk({nm, "_res"},   rsp_result1,     exp_res);
        chk({nm, "_err"},   32'(rsp_error1), 32'(exp_err));
        chk({nm, "_tag"},   32'(rsp_tag1),   32'(tag));
        for (int i = 0; i < stall; i++) begin
            idle_step(1'b0, 1'b0);
            chk({nm, "_hold_res"}, rsp_result1,    exp_res);
            chk({nm, "_hold_rdy"}, 32'(cmd_ready1), 32'd0);
        end
        idle_step(1'b1, 1'b0);
        chk({nm, "_done_rdy"}, 32'(cmd_ready1), 32'd1);
        chk({nm, "_cnt"},      32'(err_count1), 32'(exp_cnt));
        chk({nm, "_cnt2"},     32'(err_count2), 32'(exp_cnt2));
    endtask

    initial begin
        logic [31:0] edges [5];
        logic [2:0]  ill_op;
        logic [31:0] ra, rb;
        edges[0] = 32'h0000_0000; edges[1] = 32'h0000_0001; edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000; edges[4] = 32'hFFFF_FFFF;
`ifdef ALU_DRV_OPCHK_EN
        ill_op = 3'b010;
`else
        ill_op = 3'b110;
`endif

        // Reset values.
        idle_step(1'b1, 1'b1);
        idle_step(1'b1, 1'b1);
        chk("rst_cmd_ready", 32'(cmd_ready1), 32'd1);
        chk("rst_busy",      32'(busy1),      32'd0);
        chk("rst_alu_a",     alu_a1,          32'd0);
        chk("rst_alu_op",    32'(alu_op1),    32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("rst_rsp_res",   rsp_result1,     32'd0);
        chk("rst_rsp_tag",   32'(rsp_tag1),   32'd0);
        chk("rst_err_count", 32'(err_count1), 32'd0);
        idle_step(1'b1, 1'b0);

        // Directed commands.
        run_cmd("add",     32'd5,         32'd7,         3'b000, 4'd3, 0, 3'b000, 32'd12,        1'b0, 0, 0);
        run_cmd("add_ovf", 32'h7FFF_FFFF, 32'd1,         3'b000, 4'd1, 0, 3'b000, 32'h8000_0000, 1'b1, 1, 1);
        run_cmd("sub_ovf", 32'h8000_0000, 32'd1,         3'b001, 4'd2, 0, 3'b001, 32'h7FFF_FFFF, 1'b1, 2, 2);
        run_cmd("xor_bp",  32'hFFFF_0000, 32'h0F0F_0F0F, 3'b100, 4'd4, 5, 3'b100, 32'hF0F0_0F0F, 1'b0, 2, 2);
        run_cmd("op110",   32'd1,         32'd1,         3'b110, 4'd6, 0, ill_op, 32'd0,         1'b1, 3, 3);
        run_cmd("op111",   32'd2,         32'd3,         3'b111, 4'd8, 1, (ill_op | 3'b001) & ((ill_op == 3'b010) ? 3'b010 : 3'b111),
                32'd0, 1'b1, 4, 3);

        // Reset while in CAPT drops the command.
        step(1'b1, 32'd9, 32'd4, 3'b001, 4'd7, 1'b1, 1'b0);
        idle_step(1'b1, 1'b0);
        idle_step(1'b1, 1'b1);
        chk("mid_rst_valid", 32'(rsp_valid1), 32'd0);
        chk("mid_rst_rdy",   32'(cmd_ready1), 32'd1);
        chk("mid_rst_cnt",   32'(err_count1), 32'd0);
        idle_step(1'b1, 1'b0);
        idle_step(1'b1, 1'b0);
        chk("post_rst_valid", 32'(rsp_valid1), 32'd0);
        run_cmd("and_after", 32'h0000_00F0, 32'h0000_003C, 3'b010, 4'd5, 0, 3'b010, 32'h0000_0030, 1'b0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2500; n++) begin
            ra = ($urandom_range(3) == 0) ? edges[$urandom_range(4)] : $urandom;
            rb = ($urandom_range(3) == 0) ? edges[$urandom_range(4)] : $urandom;
            step(1'($urandom_range(3) != 0), ra, rb, 3'($urandom_range(7)),
                 4'($urandom_range(15)), 1'($urandom_range(3) != 0),
                 1'($urandom_range(399) == 0));
        end
        idle_step(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
